// File: rtl/mipi_dphy_pkg.sv
// Shared DPHY lane definitions: word width, sync byte, lane state and bit-order helper.
package mipi_dphy_pkg;

    localparam int unsigned DATA_W        = 16;
    localparam int unsigned OFF_W         = 4;
    localparam logic [7:0]  SYNC_BYTE_DEF = 8'hB8;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_HUNT   = 2'd1,
        ST_LOCKED = 2'd2,
        ST_ERROR  = 2'd3
    } lane_state_e;

    // Mirror a raw word so the earliest wire bit lands in bit 0.
    function automatic logic [DATA_W-1:0] bit_rev16(input logic [DATA_W-1:0] d);
        logic [DATA_W-1:0] r;
        for (int i = 0; i < DATA_W; i++) begin
            r[i] = d[DATA_W-1-i];
        end
        return r;
    endfunction

endpackage

// File: rtl/mipi_rx_lane_aligner_if.sv
// Per-lane bundle between the DPHY RX macro side and the lane aligner.
interface mipi_rx_lane_aligner_if;
    import mipi_dphy_pkg::*;

    logic              hs_en;
    logic [DATA_W-1:0] data_in;
    logic [DATA_W-1:0] data_out;
    logic              data_valid;
    logic              locked;
    logic [OFF_W-1:0]  sync_offset;
    logic              sync_err;
    logic              eot;

    modport master (
        output hs_en, data_in,
        input  data_out, data_valid, locked, sync_offset, sync_err, eot
    );

    modport slave (
        input  hs_en, data_in,
        output data_out, data_valid, locked, sync_offset, sync_err, eot
    );

endinterface

// File: rtl/mipi_rx_sync_search.sv
// Priority encoder: lowest bit offset (0..15) in a 32-bit window holding the sync byte.
module mipi_rx_sync_search
    import mipi_dphy_pkg::*;
(
    input  logic [2*DATA_W-1:0] i_win,
    input  logic [7:0]          i_sync,
    output logic                o_hit_c,
    output logic [OFF_W-1:0]    o_off_c
);

    // Scan from the top down so the lowest matching offset is the last one written.
    always_comb begin
        o_hit_c = 1'b0;
        o_off_c = '0;
        for (int o = DATA_W - 1; o >= 0; o--) begin
            if (i_win[o +: 8] == i_sync) begin
                o_hit_c = 1'b1;
                o_off_c = OFF_W'(o);
            end
        end
    end

endmodule

// File: rtl/mipi_rx_lane_aligner.sv
// One-lane HS receive aligner: hunts the sync byte at any bit offset, then emits byte-aligned words.
module mipi_rx_lane_aligner
    import mipi_dphy_pkg::*;
#(
    parameter logic [7:0]  SYNC_BYTE    = SYNC_BYTE_DEF,
    parameter int unsigned HUNT_TIMEOUT = 64,
    parameter bit          BIT_REV      = 1'b0
) (
    input  logic                   clk_byte,
    input  logic                   reset_n,
    mipi_rx_lane_aligner_if.slave  lane
);

    localparam int unsigned    CNT_W    = $clog2(HUNT_TIMEOUT) + 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(HUNT_TIMEOUT - 1);
    localparam logic [CNT_W-1:0] CNT_MAX  = '1;

    logic [DATA_W-1:0]   w_din;
    logic [DATA_W-1:0]   r_d0, r_d1, r_d2;
    logic                r_en0, r_en1, r_en2;
    logic [3*DATA_W-1:0] w_x;
    logic                w_hit;
    logic [OFF_W-1:0]    w_hit_off;
    logic                w_match;

    lane_state_e         r_state, w_state_nx;
    logic [CNT_W-1:0]    r_cnt, w_cnt_nx;
    logic [DATA_W-1:0]   r_dout, w_dout_nx;
    logic                r_dv, w_dv_nx;
    logic                r_lock, w_lock_nx;
    logic [OFF_W-1:0]    r_off, w_off_nx;
    logic                r_err, w_err_nx;
    logic                r_eot, w_eot_nx;

    // Payload word that starts right after a sync byte at the given offset.
    function automatic logic [DATA_W-1:0] payload_at(input logic [3*DATA_W-1:0] x,
                                                     input logic [OFF_W-1:0]    off);
        return DATA_W'(x >> (32'(off) + 32'd8));
    endfunction

    assign w_din   = BIT_REV ? bit_rev16(lane.data_in) : lane.data_in;
    assign w_x     = {r_d0, r_d1, r_d2};
    assign w_match = w_hit & r_en1 & r_en2;

    mipi_rx_sync_search u_search (
        .i_win   (w_x[2*DATA_W-1:0]),
        .i_sync  (SYNC_BYTE),
        .o_hit_c (w_hit),
        .o_off_c (w_hit_off)
    );

    // Three-word raw history and its hs_en qualifiers.
    always_ff @(posedge clk_byte or negedge reset_n) begin
        if (!reset_n) begin
            r_d0  <= '0;
            r_d1  <= '0;
            r_d2  <= '0;
            r_en0 <= 1'b0;
            r_en1 <= 1'b0;
            r_en2 <= 1'b0;
        end else begin
            r_d0  <= w_din;
            r_d1  <= r_d0;
            r_d2  <= r_d1;
            r_en0 <= lane.hs_en;
            r_en1 <= r_en0;
            r_en2 <= r_en1;
        end
    end

    always_ff @(posedge clk_byte or negedge reset_n) begin
        if (!reset_n) begin
            r_state <= ST_IDLE;
            r_cnt   <= '0;
            r_dout  <= '0;
            r_dv    <= 1'b0;
            r_lock  <= 1'b0;
            r_off   <= '0;
            r_err   <= 1'b0;
            r_eot   <= 1'b0;
        end else begin
            r_state <= w_state_nx;
            r_cnt   <= w_cnt_nx;
            r_dout  <= w_dout_nx;
            r_dv    <= w_dv_nx;
            r_lock  <= w_lock_nx;
            r_off   <= w_off_nx;
            r_err   <= w_err_nx;
            r_eot   <= w_eot_nx;
        end
    end

    // Lane FSM; a low en0 overrides every state so burst end beats a same-cycle match.
    always_comb begin
        w_state_nx = r_state;
        w_cnt_nx   = r_cnt;
        w_dout_nx  = r_dout;
        w_dv_nx    = r_dv;
        w_lock_nx  = r_lock;
        w_off_nx   = r_off;
        w_err_nx   = 1'b0;
        w_eot_nx   = 1'b0;

        if (!r_en0) begin
            w_state_nx = ST_IDLE;
            w_cnt_nx   = '0;
            w_dv_nx    = 1'b0;
            w_lock_nx  = 1'b0;
            w_eot_nx   = (r_state == ST_LOCKED);
        end else begin
            unique case (r_state)
                ST_IDLE: begin
                    w_state_nx = ST_HUNT;
                    w_cnt_nx   = '0;
                end
                ST_HUNT: begin
                    if (r_cnt != CNT_MAX) begin
                        w_cnt_nx = r_cnt + CNT_W'(1);
                    end
                    // The word following the sync byte is already in the window, emit it now.
                    if (w_match) begin
                        w_state_nx = ST_LOCKED;
                        w_off_nx   = w_hit_off;
                        w_lock_nx  = 1'b1;
                        w_dout_nx  = payload_at(w_x, w_hit_off);
                        w_dv_nx    = 1'b1;
                    end else if (r_cnt >= CNT_LAST) begin
                        w_state_nx = ST_ERROR;
                        w_err_nx   = 1'b1;
                    end
                end
                ST_LOCKED: begin
                    w_dout_nx = payload_at(w_x, r_off);
                    w_dv_nx   = 1'b1;
                end
                ST_ERROR: begin
                    w_state_nx = ST_ERROR;
                end
                default: begin
                    w_state_nx = ST_IDLE;
                end
            endcase
        end
    end

    assign lane.data_out    = r_dout;
    assign lane.data_valid  = r_dv;
    assign lane.locked      = r_lock;
    assign lane.sync_offset = r_off;
    assign lane.sync_err    = r_err;
    assign lane.eot         = r_eot;

endmodule

// File: tb/tb_mipi_rx_lane_aligner.sv
// Randomised bench for the lane aligner: a bit-stream reference model checks a normal and a BIT_REV lane every cycle.
module tb_mipi_rx_lane_aligner;
    import mipi_dphy_pkg::*;

    localparam int HUNT_LIMIT = 64;
    localparam int M_IDLE = 0, M_HUNT = 1, M_LOCK = 2, M_ERR = 3;

    logic        clk_byte = 1'b0;
    logic        reset_n  = 1'b0;
    logic        tb_hs_en = 1'b0;
    logic [15:0] tb_data  = 16'h0;
    logic [7:0]  sync_b   = 8'hB8;
    bit          cmp_en   = 1'b0;

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk_byte = ~clk_byte;

    function automatic logic [15:0] rev16(input logic [15:0] d);
        logic [15:0] r;
        for (int i = 0; i < 16; i++) r[i] = d[15-i];
        return r;
    endfunction

    mipi_rx_lane_aligner_if lane0 ();
    mipi_rx_lane_aligner_if lane1 ();

    assign lane0.hs_en   = tb_hs_en;
    assign lane0.data_in = tb_data;
    assign lane1.hs_en   = tb_hs_en;
    assign lane1.data_in = rev16(tb_data);

    mipi_rx_lane_aligner #(.SYNC_BYTE(8'hB8), .HUNT_TIMEOUT(64), .BIT_REV(1'b0)) dut0 (
        .clk_byte (clk_byte),
        .reset_n  (reset_n),
        .lane     (lane0)
    );

    mipi_rx_lane_aligner #(.SYNC_BYTE(8'hB8), .HUNT_TIMEOUT(64), .BIT_REV(1'b1)) dut1 (
        .clk_byte (clk_byte),
        .reset_n  (reset_n),
        .lane     (lane1)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Reference model: last three sampled words form a bit stream, earliest bit at the bottom.
    logic [15:0] h0 = '0, h1 = '0, h2 = '0;
    bit          he0 = 0, he1 = 0, he2 = 0;
    int          m_mode = M_IDLE;
    int          m_hunt_cycles = 0;
    logic [15:0] m_dout = '0;
    bit          m_dv = 0, m_lock = 0, m_err = 0, m_eot = 0;
    int          m_off = 0;

    task automatic model_step();
        logic [63:0] x;
        int          o;
        m_err = 0;
        m_eot = 0;
        if (!reset_n) begin
            h0 = '0; h1 = '0; h2 = '0; he0 = 0; he1 = 0; he2 = 0;
            m_mode = M_IDLE; m_hunt_cycles = 0;
            m_dout = '0; m_dv = 0; m_lock = 0; m_off = 0;
            return;
        end
        x = {16'h0, h0, h1, h2};
        if (!he0) begin
            if (m_mode == M_LOCK) m_eot = 1;
            m_mode = M_IDLE; m_dv = 0; m_lock = 0; m_hunt_cycles = 0;
        end else if (m_mode == M_IDLE) begin
            m_mode = M_HUNT; m_hunt_cycles = 0;
        end else if (m_mode == M_HUNT) begin
            o = -1;
            for (int k = 15; k >= 0; k--) if (x[k +: 8] == sync_b) o = k;
            m_hunt_cycles++;
            if (o >= 0 && he1 && he2) begin
                m_mode = M_LOCK; m_off = o; m_lock = 1; m_dv = 1;
                m_dout = 16'(x >> (o + 8));
            end else if (m_hunt_cycles == HUNT_LIMIT) begin
                m_mode = M_ERR; m_err = 1;
            end
        end else if (m_mode == M_LOCK) begin
            m_dout = 16'(x >> (m_off + 8));
            m_dv = 1;
        end
        h2 = h1; h1 = h0; h0 = tb_data;
        he2 = he1; he1 = he0; he0 = tb_hs_en;
    endtask

    initial forever begin
        @(posedge clk_byte or negedge reset_n);
        model_step();
    end

    // Observed valid words and eot pulses, for the directed expectations.
    logic [15:0] q0[$];
    logic [15:0] q1[$];
    int eot_cnt0 = 0, eot_cnt1 = 0;

    task automatic cmp_lane(input string tag, input logic [15:0] dout, input logic dv,
                            input logic lock, input logic [3:0] off, input logic err, input logic eot);
        chk({tag, ".data_out"},    32'(dout), 32'(m_dout));
        chk({tag, ".data_valid"},  32'(dv),   32'(m_dv));
        chk({tag, ".locked"},      32'(lock), 32'(m_lock));
        chk({tag, ".sync_offset"}, 32'(off),  32'(m_off));
        chk({tag, ".sync_err"},    32'(err),  32'(m_err));
        chk({tag, ".eot"},         32'(eot),  32'(m_eot));
    endtask

    initial forever begin
        @(negedge clk_byte);
        if (cmp_en) begin
            cmp_lane("lane0", lane0.data_out, lane0.data_valid, lane0.locked,
                     lane0.sync_offset, lane0.sync_err, lane0.eot);
            cmp_lane("lane1", lane1.data_out, lane1.data_valid, lane1.locked,
                     lane1.sync_offset, lane1.sync_err, lane1.eot);
            if (lane0.data_valid) q0.push_back(lane0.data_out);
            if (lane1.data_valid) q1.push_back(lane1.data_out);
            if (lane0.eot) eot_cnt0++;
            if (lane1.eot) eot_cnt1++;
        end
    end

    task automatic drive(input logic en, input logic [15:0] w);
        @(negedge clk_byte);
        tb_hs_en = en;
        tb_data  = w;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) drive(1'b0, 16'h0);
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, " l0 data_out"}, 32'(lane0.data_out), 32'h0);
        chk({tag, " l0 valid"},    32'(lane0.data_valid), 32'h0);
        chk({tag, " l0 locked"},   32'(lane0.locked), 32'h0);
        chk({tag, " l0 offset"},   32'(lane0.sync_offset), 32'h0);
        chk({tag, " l0 err"},      32'(lane0.sync_err), 32'h0);
        chk({tag, " l0 eot"},      32'(lane0.eot), 32'h0);
        chk({tag, " l1 data_out"}, 32'(lane1.data_out), 32'h0);
        chk({tag, " l1 locked"},   32'(lane1.locked), 32'h0);
    endtask

    // Sync byte placed `off` bits after `pre` zero words, followed by random payload bytes.
    task automatic send_sync_burst(input int pre, input int off, input int nbytes, input int maxw);
        bit          q[$];
        logic [15:0] w;
        logic [7:0]  rb;
        int          nw;
        for (int i = 0; i < pre * 16 + off; i++) q.push_back(1'b0);
        for (int i = 0; i < 8; i++) q.push_back(sync_b[i]);
        for (int b = 0; b < nbytes; b++) begin
            rb = 8'($urandom);
            for (int i = 0; i < 8; i++) q.push_back(rb[i]);
        end
        nw = 0;
        while (q.size() >= 16 && nw < maxw) begin
            for (int i = 0; i < 16; i++) w[i] = q.pop_front();
            drive(1'b1, w);
            nw++;
        end
    endtask

    initial begin : watchdog
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin : stimulus
        int err_idx, err_cnt, dv_seen;
        repeat (3) @(negedge clk_byte);
        cmp_en = 1'b1;
        chk_all_zero("reset");
        reset_n = 1'b1;
        idle(3);

        // Offset 0, plus the reversed copy on lane1; burst end must give one eot.
        q0.delete(); q1.delete(); eot_cnt0 = 0; eot_cnt1 = 0;
        drive(1, 16'h0000); drive(1, 16'h12B8); drive(1, 16'h5634); drive(1, 16'h9A78);
        for (int i = 0; i < 4; i++) drive(1, 16'($urandom));
        chk("t1 sync_offset", 32'(lane0.sync_offset), 32'd0);
        chk("t1 locked", 32'(lane0.locked), 32'd1);
        idle(4);
        chk("t1 nwords", 32'(q0.size() >= 2), 32'd1);
        if (q0.size() >= 2) begin
            chk("t1 word0", 32'(q0[0]), 32'h3412);
            chk("t1 word1", 32'(q0[1]), 32'h7856);
        end
        chk("t6 nwords", 32'(q1.size() >= 2), 32'd1);
        if (q1.size() >= 2) begin
            chk("t6 word0", 32'(q1[0]), 32'h3412);
            chk("t6 word1", 32'(q1[1]), 32'h7856);
        end
        chk("t6 sync_offset", 32'(lane1.sync_offset), 32'd0);
        chk("t4 eot count", 32'(eot_cnt0), 32'd1);
        chk("t4 eot count l1", 32'(eot_cnt1), 32'd1);
        chk("t4 valid low", 32'(lane0.data_valid), 32'd0);
        chk("t4 locked low", 32'(lane0.locked), 32'd0);

        // Offset 3 in a fresh burst: re-hunt after the previous lock.
        q0.delete();
        drive(1, 16'h0000); drive(1, 16'h95C0); drive(1, 16'hB1A0); drive(1, 16'hD3C2);
        drive(1, 16'h0004); drive(1, 16'h0000); drive(1, 16'h0000);
        chk("t2 sync_offset", 32'(lane0.sync_offset), 32'd3);
        idle(3);
        chk("t2 nwords", 32'(q0.size() >= 2), 32'd1);
        if (q0.size() >= 2) begin
            chk("t2 word0", 32'(q0[0]), 32'h3412);
            chk("t2 word1", 32'(q0[1]), 32'h7856);
        end

        // No sync: one sync_err pulse after 64 hunt cycles.
        err_idx = -1; err_cnt = 0; dv_seen = 0;
        for (int i = 0; i < 70; i++) begin
            drive(1, 16'h0000);
            if (lane0.sync_err) begin err_cnt++; err_idx = i; end
            if (lane0.data_valid || lane0.locked) dv_seen++;
        end
        chk("t3 err pulses", 32'(err_cnt), 32'd1);
        chk("t3 err cycle", 32'(err_idx), 32'd66);
        chk("t3 no valid/lock", 32'(dv_seen), 32'd0);
        idle(3);

        // Reset while locked: outputs clear immediately, stay idle until hs_en rises.
        drive(1, 16'h0000); drive(1, 16'h12B8); drive(1, 16'h5634); drive(1, 16'h9A78);
        drive(1, 16'hBEEF); drive(1, 16'hCAFE);
        chk("t5 locked before", 32'(lane0.locked), 32'd1);
        #2 reset_n = 1'b0;
        #1 chk_all_zero("t5 async");
        drive(1, 16'h1234); drive(1, 16'h5678);
        tb_hs_en = 1'b0; reset_n = 1'b1;
        idle(3);
        chk("t5 idle locked", 32'(lane0.locked), 32'd0);
        chk("t5 idle valid", 32'(lane0.data_valid), 32'd0);

        // Random bursts checked cycle by cycle against the model.
        for (int b = 0; b < 60; b++) begin
            int k;
            k = int'($urandom_range(0, 9));
            if (k < 5)
                send_sync_burst(int'($urandom_range(0, 3)), int'($urandom_range(0, 15)),
                                int'($urandom_range(2, 24)), 100);
            else if (k < 7)
                send_sync_burst(int'($urandom_range(0, 1)), int'($urandom_range(0, 15)),
                                8, int'($urandom_range(1, 4)));
            else if (k < 9)
                for (int i = 0; i < int'($urandom_range(1, 20)); i++) drive(1, 16'($urandom));
            else
                for (int i = 0; i < 68; i++) drive(1, 16'h0000);
            idle(int'($urandom_range(1, 3)));
        end
        idle(4);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
